rr_out_alloc_5: RTL and testbench
=================================

# rr_out_alloc_5

Round-robin, wormhole-locking output allocator for one router output port. It arbitrates among the five router inputs (local, N, E, S, W) requesting this output and holds the winner until the packet's tail flit has transferred. It sits directly upstream of the 5-way one-hot output multiplexer. Its registered one-hot `grant_o` drives the multiplexer select, and `valid_o` qualifies the multiplexed flit to the downstream link.

## Interface
- `RST_PTR`, default 0: round-robin pointer value after reset, range 0..4.
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  reset: asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `req_i`  in  5  bit i = input i holds a flit routed to this output.
- `head_i`  in  5  bit i = input i's current flit is a head flit. Meaningful only when `req_i[i]`=1.
- `tail_i`  in  5  bit i = input i's current flit is a tail flit. Meaningful only when `req_i[i]`=1. Head and tail may both be set for a single-flit packet.
- `ready_i`  in  1  downstream can accept a flit this cycle.
- `grant_o`  out  5  one-hot owner select; 5'b00000 when idle. Drives the mux select.
- `valid_o`  out  1  multiplexed flit is valid this cycle.
- `fire_o`  out  5  one-hot pop strobe to the owning input buffer (= `grant_o` when a transfer occurs).
- `busy_o`  out  1  allocator is locked to an owner.

## Operation
- State: `IDLE` / `LOCKED`, plus a 3-bit `owner` register and a 3-bit round-robin pointer `ptr` (values 0..4).
- Eligible set in `IDLE`: `elig = req_i & head_i`. Body or tail flits never win arbitration.
- Arbitration in `IDLE`:
  - Winner = first eligible index scanning ptr, ptr+1, …, wrapping mod 5.
  - If any index is eligible, go to `LOCKED` with `owner` = winner.
  - Arbitration does not depend on `ready_i`.
- `LOCKED` behaviour:
  - `grant_o` = onehot(`owner`).
  - `valid_o` = `req_i[owner]`.
  - transfer = `valid_o & ready_i`.
  - `fire_o` = transfer ? `grant_o` : 0.
- Packet end: transfer with `tail_i[owner]`=1 → `IDLE`, and `ptr` ← (`owner`+1) mod 5. Fairness rotates per packet, not per flit.
- Stall: `req_i[owner]`=0 in `LOCKED` (upstream bubble) → stay `LOCKED`, `valid_o`=0, no pointer change.
- Ignored inputs:
  - `head_i[owner]` while `LOCKED` is ignored.
  - Requests from non-owners while `LOCKED` are ignored; they do not move `ptr`.
- `IDLE` outputs: `grant_o`=0, `valid_o`=0, `fire_o`=0, `busy_o`=0.
- `busy_o` = (state == `LOCKED`).
- Invariants:
  - `grant_o` and `fire_o` are always zero or one-hot.
  - `fire_o` ⊆ `grant_o`.
  - `owner` is always in 0..4.
  - Values 5..7 in `owner` or `ptr` are unreachable; if forced, treat them as 0.

## Timing
- Reset (async assert, sync to clock on release):
  - state = `IDLE`, `ptr` = `RST_PTR`, `owner` = 0.
  - All outputs are 0 immediately on assertion, without waiting for a clock edge.
- Allocation latency: head requested at edge N-1..N → `grant_o` and `valid_o` high in cycle N+1 (one cycle of arbitration). The earliest transfer is in cycle N+1.
- `grant_o` and `busy_o` are registered and glitch-free.
- `valid_o` and `fire_o` are combinational from `req_i` and `ready_i` ANDed with registered state.
- Throughput: one flit per cycle while locked and `ready_i`=1.
- Idle gap: one `IDLE` cycle between consecutive packets (tail transfer at cycle T → `IDLE` at T+1 → next owner at T+2).
- Single-flit packet: head+tail transfer in the first locked cycle → `IDLE` on the next cycle.
- Reset asserted mid-packet: the lock is dropped immediately, and the partial packet is the upstream's responsibility.

## Test plan
- **Reset:** with `RST_PTR`=0, assert `rst` asynchronously mid-cycle while `LOCKED`.
  - Required: `grant_o`=0 and `busy_o`=0 before the next edge.
  - After release, `req_i`=5'b00100 as a head gives `grant_o`=5'b00100 one cycle later.
- **Round-robin rotation:** `req_i`=`head_i`=5'b11111 continuously, single-flit packets, `ready_i`=1.
  - Required: grant sequence 00001, 00010, 00100, 01000, 10000, 00001, each separated by one idle cycle.
- **Wormhole lock:** input 1 sends a 4-flit packet (head, body, body, tail); at the body flits input 3 raises a head.
  - Required: `grant_o` stays 5'b00010 for 4 transfers, then `IDLE`, then 5'b01000.
- **Backpressure and bubbles:** during a 3-flit packet from input 4, toggle `ready_i` 1,0,0,1,1 and drop `req_i[4]` for one cycle.
  - Required: `fire_o`=5'b10000 only when `req_i[4]`&`ready_i`; exactly 3 fires; release after the tail fire.
- **Non-head filter:** in `IDLE`, `req_i`=5'b01001 with `head_i`=5'b01000, `ptr`=0.
  - Required: the winner is input 3 (5'b01000); input 0 is not granted.
- **Wrap-around:** `ptr`=4 (after input 3 finishes), `req_i`=`head_i`=5'b00011.
  - Required: the winner is input 0, then `ptr`=1.

Source files
------------

// File: rtl/rr_out_alloc_5.sv
// Round-robin, wormhole-locking allocator for one 5-input router output port.
// Locks to a head-flit winner and holds the grant until that packet's tail transfers.
module rr_out_alloc_5 #(
    parameter int RST_PTR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req_i,
    input  logic [4:0] head_i,
    input  logic [4:0] tail_i,
    input  logic       ready_i,
    output logic [4:0] grant_o,
    output logic       valid_o,
    output logic [4:0] fire_o,
    output logic       busy_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [2:0] RST_PTR_L = (RST_PTR >= 0 && RST_PTR <= 4) ? 3'(RST_PTR) : 3'd0;

    state_t     state_reg, state_next;
    logic [2:0] owner_reg, owner_next;
    logic [2:0] ptr_reg, ptr_next;
    logic [4:0] grant_reg, grant_next;

    logic [2:0] owner_safe, ptr_safe;
    logic [4:0] elig, elig_rot;
    logic [9:0] elig_dbl;
    logic [2:0] win_off, winner;
    logic [4:0] owner_onehot_next;
    logic       transfer, tail_owner;

    function automatic logic [2:0] add_mod5(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
    endfunction

    // Out-of-range encodings can only appear if forced; fold them onto input 0.
    assign owner_safe = (owner_reg > 3'd4) ? 3'd0 : owner_reg;
    assign ptr_safe   = (ptr_reg > 3'd4) ? 3'd0 : ptr_reg;

    assign elig     = req_i & head_i;
    assign elig_dbl = {elig, elig};
    assign elig_rot = elig_dbl[ptr_safe +: 5];

    always_comb begin
        win_off = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (elig_rot[k]) win_off = 3'(k);
        end
    end

    assign winner = add_mod5(ptr_safe, win_off);

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_onehot
            assign owner_onehot_next[gi] = (owner_next == 3'(gi));
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            owner_reg <= 3'd0;
            ptr_reg   <= RST_PTR_L;
            grant_reg <= 5'b00000;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
        end
    end

    // Next-state logic; the pointer only advances at a packet boundary
    always_comb begin
        state_next = state_reg;
        owner_next = owner_safe;
        ptr_next   = ptr_safe;
        case (state_reg)
            IDLE: begin
                if (|elig) begin
                    state_next = LOCKED;
                    owner_next = winner;
                end
            end
            LOCKED: begin
                if (transfer && tail_owner) begin
                    state_next = IDLE;
                    ptr_next   = add_mod5(owner_safe, 3'd1);
                end
            end
            default: state_next = IDLE;
        endcase
        grant_next = (state_next == LOCKED) ? owner_onehot_next : 5'b00000;
    end

    // Outputs: grant/busy straight from flops, valid/fire gated by live request and ready
    always_comb begin
        grant_o    = grant_reg;
        busy_o     = (state_reg == LOCKED);
        valid_o    = busy_o && |(req_i & grant_reg);
        transfer   = valid_o && ready_i;
        fire_o     = transfer ? grant_reg : 5'b00000;
        tail_owner = |(tail_i & grant_reg);
    end

endmodule

// File: tb/tb_rr_out_alloc_5.sv
// Table-driven bench for rr_out_alloc_5 with a queue scoreboard checked mid-cycle,
// plus a hand-written asynchronous mid-packet reset sequence.
module tb_rr_out_alloc_5;

    logic       clk;
    logic       rst;
    logic [4:0] req_i, head_i, tail_i;
    logic       ready_i;
    logic [4:0] grant_o, fire_o;
    logic       valid_o, busy_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         rst_before;
        logic [4:0] req, head, tail;
        logic       ready;
        logic [4:0] grant;
        logic       valid;
        logic [4:0] fire;
        logic       busy;
    } vec_t;

    typedef struct {
        int         idx;
        logic [4:0] grant;
        logic       valid;
        logic [4:0] fire;
        logic       busy;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    rr_out_alloc_5 #(.RST_PTR(0)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .head_i  (head_i),
        .tail_i  (tail_i),
        .ready_i (ready_i),
        .grant_o (grant_o),
        .valid_o (valid_o),
        .fire_o  (fire_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, logic [4:0] req, logic [4:0] head, logic [4:0] tail,
                                logic rdy, logic [4:0] g, logic v, logic [4:0] f, logic b);
        vec_t t;
        t.rst_before = r; t.req = req; t.head = head; t.tail = tail; t.ready = rdy;
        t.grant = g; t.valid = v; t.fire = f; t.busy = b;
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [4:0] act, logic [4:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s vec=%0d got=%b want=%b", name, idx, act, expv);
        end
    endtask

    // Scoreboard: outputs for the cycle just driven are compared on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("grant", e.idx, grant_o, e.grant);
            chk("valid", e.idx, {4'b0, valid_o}, {4'b0, e.valid});
            chk("fire",  e.idx, fire_o, e.fire);
            chk("busy",  e.idx, {4'b0, busy_o}, {4'b0, e.busy});
            $display("vec %0d: grant=%b valid=%b fire=%b busy=%b", e.idx, grant_o, valid_o, fire_o, busy_o);
        end
    end

    task automatic apply(vec_t v, int idx);
        exp_t e;
        @(posedge clk);
        #1;
        req_i = v.req; head_i = v.head; tail_i = v.tail; ready_i = v.ready;
        e.idx = idx; e.grant = v.grant; e.valid = v.valid; e.fire = v.fire; e.busy = v.busy;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        req_i = '0; head_i = '0; tail_i = '0; ready_i = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        // Round-robin rotation with single-flit packets
        vecs.push_back(mk(1, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00001, 1, 5'b00001, 1));
        vecs.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00010, 1, 5'b00010, 1));
        vecs.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00100, 1, 5'b00100, 1));
        vecs.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b01000, 1, 5'b01000, 1));
        vecs.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b10000, 1, 5'b10000, 1));
        vecs.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00001, 1, 5'b00001, 1));
        // Wormhole lock of input 1, input 3 waiting, then wrap-around from ptr=4
        vecs.push_back(mk(1, 5'b00010, 5'b00010, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b00010, 5'b00010, 5'b00000, 1, 5'b00010, 1, 5'b00010, 1));
        vecs.push_back(mk(0, 5'b01010, 5'b01000, 5'b00000, 1, 5'b00010, 1, 5'b00010, 1));
        vecs.push_back(mk(0, 5'b01010, 5'b01000, 5'b00000, 1, 5'b00010, 1, 5'b00010, 1));
        vecs.push_back(mk(0, 5'b01010, 5'b01000, 5'b00010, 1, 5'b00010, 1, 5'b00010, 1));
        vecs.push_back(mk(0, 5'b01000, 5'b01000, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b01000, 5'b01000, 5'b01000, 1, 5'b01000, 1, 5'b01000, 1));
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b00011, 5'b00011, 5'b00011, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b00011, 5'b00011, 5'b00011, 1, 5'b00001, 1, 5'b00001, 1));
        vecs.push_back(mk(0, 5'b00011, 5'b00011, 5'b00011, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b00011, 5'b00011, 5'b00011, 1, 5'b00010, 1, 5'b00010, 1));
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0));
        // Backpressure and a bubble during a 3-flit packet from input 4
        vecs.push_back(mk(1, 5'b10000, 5'b10000, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b10000, 5'b10000, 5'b00000, 1, 5'b10000, 1, 5'b10000, 1));
        vecs.push_back(mk(0, 5'b10000, 5'b00000, 5'b00000, 0, 5'b10000, 1, 5'b00000, 1));
        vecs.push_back(mk(0, 5'b10000, 5'b00000, 5'b00000, 0, 5'b10000, 1, 5'b00000, 1));
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b10000, 0, 5'b00000, 1));
        vecs.push_back(mk(0, 5'b10000, 5'b00000, 5'b00000, 1, 5'b10000, 1, 5'b10000, 1));
        vecs.push_back(mk(0, 5'b10000, 5'b00000, 5'b10000, 1, 5'b10000, 1, 5'b10000, 1));
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0));
        // Non-head filter: input 0 requests with a body flit and must never win
        vecs.push_back(mk(1, 5'b01001, 5'b01000, 5'b01001, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b01001, 5'b01000, 5'b01001, 1, 5'b01000, 1, 5'b01000, 1));
        vecs.push_back(mk(0, 5'b01001, 5'b00000, 5'b01001, 1, 5'b00000, 0, 5'b00000, 0));
        vecs.push_back(mk(0, 5'b01001, 5'b00000, 5'b01001, 1, 5'b00000, 0, 5'b00000, 0));

        rst = 1'b1;
        req_i = '0; head_i = '0; tail_i = '0; ready_i = 1'b0;
        #2;
        chk("rst_grant", -1, grant_o, 5'b00000);
        chk("rst_valid", -1, {4'b0, valid_o}, 5'b00000);
        chk("rst_fire",  -1, fire_o, 5'b00000);
        chk("rst_busy",  -1, {4'b0, busy_o}, 5'b00000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            apply(vecs[i], i);
        end

        // Asynchronous reset asserted mid-cycle while locked
        do_reset();
        apply(mk(0, 5'b00001, 5'b00001, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0), 100);
        apply(mk(0, 5'b00001, 5'b00001, 5'b00000, 1, 5'b00001, 1, 5'b00001, 1), 101);
        @(posedge clk);
        #1;
        req_i = 5'b00001; head_i = 5'b00000; tail_i = 5'b00000; ready_i = 1'b1;
        #1;
        chk("lock_before_rst", 102, grant_o, 5'b00001);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_grant", 102, grant_o, 5'b00000);
        chk("async_rst_busy",  102, {4'b0, busy_o}, 5'b00000);
        chk("async_rst_fire",  102, fire_o, 5'b00000);
        chk("async_rst_valid", 102, {4'b0, valid_o}, 5'b00000);
        $display("async reset: grant=%b busy=%b fire=%b valid=%b", grant_o, busy_o, fire_o, valid_o);
        req_i = '0; head_i = '0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        apply(mk(0, 5'b00100, 5'b00100, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0), 103);
        apply(mk(0, 5'b00100, 5'b00100, 5'b00000, 1, 5'b00100, 1, 5'b00100, 1), 104);

        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
